// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - multi-cycle RV32M DIV/DIVU/REM/REMU sequencer
//
// Ports:
//   clk_i      sole clock, rising edge
//   reset_i    synchronous active-high reset, highest priority
//   start_i    request strobe, sampled only in IDLE
//   flush_i    synchronous abort, below reset, above everything else
//   funct3_i   100 DIV, 101 DIVU, 110 REM, 111 REMU; bit 2 low ignores start_i
//   data1_i    dividend, sampled with start_i
//   data2_i    divisor, sampled with start_i
//   busy_o     high in every state except IDLE
//   done_o     one-cycle pulse, result_o valid while high
//   result_o   quotient or remainder, held until the next done_o

module div_sequencer (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic        flush_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] data1_i,
    input  logic [31:0] data2_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] result_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ITER   = 2'd1,
        S_FIX    = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t      state_q, state_d;

    logic        op_signed_q, op_signed_d;
    logic        op_rem_q,    op_rem_d;
    logic        neg1_q,      neg1_d;
    logic        neg2_q,      neg2_d;
    logic [31:0] rem_q,       rem_d;
    logic [31:0] quo_q,       quo_d;
    logic [31:0] dvsr_q,      dvsr_d;
    logic [5:0]  cnt_q,       cnt_d;
    logic [31:0] result_q,    result_d;

    // Request decode in IDLE
    logic        accept;
    logic        in_signed;
    logic        in_rem;
    logic        in_neg1;
    logic        in_neg2;
    logic [31:0] abs1;
    logic [31:0] abs2;
    logic        div_zero;
    logic        overflow;
    logic        special;
    logic [31:0] special_result;

    // Iteration and sign fix-up
    logic [32:0] trial_rem;
    logic [32:0] trial_diff;
    logic        q_neg;
    logic        r_neg;
    logic [31:0] quo_fixed;
    logic [31:0] rem_fixed;

    always_comb begin
        // A flush in the same cycle as start wins, so the request is dropped.
        accept    = (state_q == S_IDLE) && start_i && funct3_i[2] && !flush_i;
        in_signed = ~funct3_i[0];
        in_rem    = funct3_i[1];
        in_neg1   = in_signed & data1_i[31];
        in_neg2   = in_signed & data2_i[31];
        abs1      = in_neg1 ? (32'd0 - data1_i) : data1_i;
        abs2      = in_neg2 ? (32'd0 - data2_i) : data2_i;
        div_zero  = (data2_i == 32'd0);
        overflow  = in_signed && (data1_i == 32'h8000_0000) && (data2_i == 32'hFFFF_FFFF);
        special   = div_zero | overflow;
        if (div_zero) begin
            special_result = in_rem ? data1_i : 32'hFFFF_FFFF;
        end else begin
            special_result = in_rem ? 32'd0 : 32'h8000_0000;
        end
    end

    always_comb begin
        // The shifted partial remainder can reach 2*divisor-1, hence 33 bits.
        trial_rem  = {rem_q, quo_q[31]};
        trial_diff = trial_rem - {1'b0, dvsr_q};
        q_neg      = op_signed_q & (neg1_q ^ neg2_q);
        r_neg      = op_signed_q & neg1_q;
        quo_fixed  = q_neg ? (32'd0 - quo_q) : quo_q;
        rem_fixed  = r_neg ? (32'd0 - rem_q) : rem_q;
    end

    // FSM: state register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = special ? S_FINISH : S_ITER;
                end
            end
            S_ITER: begin
                if (cnt_q == 6'd31) begin
                    state_d = S_FIX;
                end
            end
            S_FIX:    state_d = S_FINISH;
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (flush_i) begin
            state_d = S_IDLE;
        end
    end

    // FSM: outputs, decoded from registered state only
    always_comb begin
        busy_o   = (state_q != S_IDLE);
        done_o   = (state_q == S_FINISH);
        result_o = result_q;
    end

    // Datapath next state
    always_comb begin
        op_signed_d = op_signed_q;
        op_rem_d    = op_rem_q;
        neg1_d      = neg1_q;
        neg2_d      = neg2_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvsr_d      = dvsr_q;
        cnt_d       = cnt_q;
        result_d    = result_q;

        // A flushed operation must leave result_q untouched.
        if (!flush_i) begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op_signed_d = in_signed;
                        op_rem_d    = in_rem;
                        neg1_d      = in_neg1;
                        neg2_d      = in_neg2;
                        rem_d       = 32'd0;
                        quo_d       = abs1;
                        dvsr_d      = abs2;
                        cnt_d       = 6'd0;
                        if (special) begin
                            result_d = special_result;
                        end
                    end
                end
                S_ITER: begin
                    if (!trial_diff[32]) begin
                        rem_d = trial_diff[31:0];
                        quo_d = {quo_q[30:0], 1'b1};
                    end else begin
                        rem_d = trial_rem[31:0];
                        quo_d = {quo_q[30:0], 1'b0};
                    end
                    cnt_d = cnt_q + 6'd1;
                end
                S_FIX: begin
                    result_d = op_rem_q ? rem_fixed : quo_fixed;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            op_signed_q <= 1'b0;
            op_rem_q    <= 1'b0;
            neg1_q      <= 1'b0;
            neg2_q      <= 1'b0;
            rem_q       <= 32'd0;
            quo_q       <= 32'd0;
            dvsr_q      <= 32'd0;
            cnt_q       <= 6'd0;
            result_q    <= 32'd0;
        end else begin
            op_signed_q <= op_signed_d;
            op_rem_q    <= op_rem_d;
            neg1_q      <= neg1_d;
            neg2_q      <= neg2_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvsr_q      <= dvsr_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// tb/tb_div_sequencer.sv - scoreboard bench for div_sequencer

module tb_div_sequencer;

    localparam logic [2:0] F_DIV  = 3'b100;
    localparam logic [2:0] F_DIVU = 3'b101;
    localparam logic [2:0] F_REM  = 3'b110;
    localparam logic [2:0] F_REMU = 3'b111;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        flush;
    logic [2:0]  funct3;
    logic [31:0] data1;
    logic [31:0] data2;
    logic        busy;
    logic        done;
    logic [31:0] result;

    always #5 clk = ~clk;

    div_sequencer dut (
        .clk_i    (clk),
        .reset_i  (reset),
        .start_i  (start),
        .flush_i  (flush),
        .funct3_i (funct3),
        .data1_i  (data1),
        .data2_i  (data2),
        .busy_o   (busy),
        .done_o   (done),
        .result_o (result)
    );

    typedef struct {
        logic [31:0] res;
        int          at;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] last_res = 32'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every DONE pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got DONE=1 with result %h at cycle %0d, expected no DONE", result, cyc);
            end else begin
                mon_e = sb.pop_front();
                check("result", result, mon_e.res);
                check("done_cycle", 32'(cyc), 32'(mon_e.at));
            end
        end
    end

    // Called just after a falling edge; the next rising edge samples START.
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input bit special);
        exp_t e;
        funct3 = f;
        data1  = a;
        data2  = b;
        start  = 1'b1;
        e.res  = exp;
        e.at   = cyc + (special ? 1 : 34);
        sb.push_back(e);
        last_res = exp;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_done();
        int t = 0;
        while (sb.size() != 0 && t < 80) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got no DONE within %0d cycles, expected result %h", t, sb[0].res);
            sb.delete();
        end
        @(negedge clk);
        check("busy_idle_after_done", {31'd0, busy}, 32'd0);
    endtask

    task automatic run(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input bit special);
        issue(f, a, b, exp, special);
        wait_done();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        flush  = 1'b0;
        funct3 = 3'b000;
        data1  = 32'd0;
        data2  = 32'd0;
        repeat (3) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Unsigned and signed normal divides
        run(F_DIVU, 32'd100,        32'd7,          32'd14,         1'b0);
        run(F_REMU, 32'd100,        32'd7,          32'd2,          1'b0);
        run(F_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1'b0);
        run(F_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  1'b0);
        run(F_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          1'b0);
        run(F_DIV,  32'h7FFF_FFFF,  32'd1,          32'h7FFF_FFFF,  1'b0);
        run(F_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  1'b0);
        run(F_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b0);
        run(F_REMU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b0);

        // Special cases
        run(F_DIVU, 32'd85,         32'd0,          32'hFFFF_FFFF,  1'b1);
        run(F_REM,  32'h0000_1234,  32'd0,          32'h0000_1234,  1'b1);
        run(F_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b1);
        run(F_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b1);

        // START held through ITER and FINISH must be ignored
        issue(F_DIVU, 32'd100, 32'd7, 32'd14, 1'b0);
        funct3 = F_REMU;
        data1  = 32'd50;
        data2  = 32'd3;
        start  = 1'b1;
        for (int i = 0; i < 80 && sb.size() != 0; i++) @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("busy_reject", {31'd0, busy}, 32'd0);
        check("busy_reject_result", result, 32'd14);
        @(negedge clk);

        // Flush at iteration 10
        funct3 = F_DIVU;
        data1  = 32'd1000;
        data2  = 32'd10;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", {31'd0, busy}, 32'd0);
        check("flush_result", result, last_res);
        repeat (40) @(negedge clk);
        check("flush_no_done", {31'd0, done}, 32'd0);
        run(F_DIVU, 32'd9, 32'd3, 32'd3, 1'b0);

        // Flush together with START in IDLE
        funct3 = F_DIV;
        data1  = 32'd20;
        data2  = 32'd4;
        start  = 1'b1;
        flush  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        check("flush_start_busy", {31'd0, busy}, 32'd0);

        // Reset in the middle of ITER
        funct3 = F_DIVU;
        data1  = 32'd500;
        data2  = 32'd5;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_done", {31'd0, done}, 32'd0);
        check("midreset_result", result, 32'd0);

        // Reset and START together
        reset  = 1'b1;
        start  = 1'b1;
        funct3 = F_DIVU;
        data1  = 32'd8;
        data2  = 32'd2;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        check("reset_start_busy", {31'd0, busy}, 32'd0);

        // FUNCT3[2]=0 never starts
        funct3 = 3'b000;
        data1  = 32'd8;
        data2  = 32'd2;
        start  = 1'b1;
        @(negedge clk);
        check("funct3_000_busy", {31'd0, busy}, 32'd0);
        start = 1'b0;
        @(negedge clk);
        check("funct3_000_result", result, 32'd0);

        run(F_REMU, 32'd1000, 32'd7, 32'd6, 1'b0);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
